// File: rtl/fft_frame_buffer_if.sv
// Streaming sample interface between the frame buffer and the FFT core.
// The master drives the samples and the slave drives the ready back-pressure.
interface fft_frame_buffer_if #(
    parameter int DATA_W = 24
);
    logic              src_valid;
    logic              src_ready;
    logic [DATA_W-1:0] src_data;
    logic              src_sop;
    logic              src_eop;

    modport master (
        output src_valid,
        output src_data,
        output src_sop,
        output src_eop,
        input  src_ready
    );

    modport slave (
        input  src_valid,
        input  src_data,
        input  src_sop,
        input  src_eop,
        output src_ready
    );
endinterface

// File: rtl/fft_frame_buffer.sv
// Captures one mono sample per LRC rising edge into a circular FIFO.
// Streams the buffered samples as FRAME_LEN-sample frames with sop/eop.
module fft_frame_buffer #(
    parameter int DATA_W    = 24,
    parameter int FRAME_LEN = 256,
    parameter int ADDR_W    = 9
) (
    input  logic              AUD_BCLK,
    input  logic              reset,
    input  logic              lrc_in,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              enable,
    fft_frame_buffer_if.master src,
    output logic [ADDR_W:0]   fill_level,
    output logic              overflow
);
    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   FRAME_L = (ADDR_W+1)'(FRAME_LEN);
    localparam logic [ADDR_W:0]   ONE_F   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(FRAME_LEN - 1);
    localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

    typedef enum logic [1:0] {S_WAIT, S_LOAD, S_STREAM} state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] frame_cnt;
    logic              lrc_q1;
    logic              lrc_q2;
    logic              strobe;
    logic              full;
    logic              capture;
    logic              xfer;

    always_comb begin
        strobe  = lrc_q1 & ~lrc_q2;
        full    = (fill_level == DEPTH_L);
        capture = strobe & ~full;
        xfer    = src.src_valid & src.src_ready;
    end

    // Storage is left unreset so it maps onto block RAM.
    always_ff @(posedge AUD_BCLK) begin
        if (capture)
            mem[wr_ptr] <= sample_in;
    end

    always_ff @(posedge AUD_BCLK) begin
        if (reset) begin
            state         <= S_WAIT;
            lrc_q1        <= 1'b0;
            lrc_q2        <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            frame_cnt     <= '0;
            fill_level    <= '0;
            overflow      <= 1'b0;
            src.src_valid <= 1'b0;
            src.src_data  <= '0;
            src.src_sop   <= 1'b0;
            src.src_eop   <= 1'b0;
        end else begin
            lrc_q1 <= lrc_in;
            lrc_q2 <= lrc_q1;

            if (capture)
                wr_ptr <= wr_ptr + ONE_A;
            if (strobe && full)
                overflow <= 1'b1;

            if (capture && !xfer)
                fill_level <= fill_level + ONE_F;
            else if (!capture && xfer)
                fill_level <= fill_level - ONE_F;

            unique case (state)
                S_WAIT: begin
                    if (enable && fill_level >= FRAME_L)
                        state <= S_LOAD;
                end
                S_LOAD: begin
                    src.src_data  <= mem[rd_ptr];
                    src.src_valid <= 1'b1;
                    src.src_sop   <= 1'b1;
                    src.src_eop   <= (LAST == '0);
                    frame_cnt     <= '0;
                    state         <= S_STREAM;
                end
                S_STREAM: begin
                    if (xfer) begin
                        rd_ptr <= rd_ptr + ONE_A;
                        if (src.src_eop) begin
                            src.src_valid <= 1'b0;
                            src.src_sop   <= 1'b0;
                            src.src_eop   <= 1'b0;
                            state         <= S_WAIT;
                        end else begin
                            // Prefetch the word after the one being accepted so
                            // back-to-back transfers run at one sample per cycle.
                            src.src_data <= mem[rd_ptr + ONE_A];
                            src.src_sop  <= 1'b0;
                            src.src_eop  <= ((frame_cnt + ONE_A) == LAST);
                            frame_cnt    <= frame_cnt + ONE_A;
                        end
                    end
                end
                default: state <= S_WAIT;
            endcase
        end
    end
endmodule

// File: tb/tb_fft_frame_buffer.sv
// Scoreboard bench for fft_frame_buffer: captured samples are queued as they are
// fed and compared, with sop/eop, frame latency and fill level, as frames stream.
module tb_fft_frame_buffer;
    localparam int FRAME = 256;
    localparam int DEPTH = 512;

    logic        AUD_BCLK = 1'b0;
    logic        reset    = 1'b1;
    logic        lrc_in   = 1'b0;
    logic [23:0] sample_in = '0;
    logic        enable   = 1'b0;
    logic [9:0]  fill_level;
    logic        overflow;

    int n_cmp = 0;
    int n_bad = 0;
    int ready_mode = 0;
    int cyc = 0;

    logic [23:0] exp_q[$];
    int          fidx = 0;
    int          m_st = 0;
    bit          exp_ovf = 1'b0;

    fft_frame_buffer_if #(.DATA_W(24)) src_if ();

    fft_frame_buffer #(
        .DATA_W(24),
        .FRAME_LEN(FRAME),
        .ADDR_W(9)
    ) dut (
        .AUD_BCLK(AUD_BCLK),
        .reset(reset),
        .lrc_in(lrc_in),
        .sample_in(sample_in),
        .enable(enable),
        .src(src_if),
        .fill_level(fill_level),
        .overflow(overflow)
    );

    initial forever #5 AUD_BCLK = ~AUD_BCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ready pattern: 0 always, 1 one-in-three, 2 random ~75%
    initial begin
        src_if.src_ready = 1'b1;
        forever begin
            @(posedge AUD_BCLK);
            #1;
            cyc++;
            case (ready_mode)
                0:       src_if.src_ready = 1'b1;
                1:       src_if.src_ready = (cyc % 3 == 0);
                default: src_if.src_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: reference frame sequencer plus scoreboard pop on each transfer.
    initial begin
        logic [23:0] e;
        logic [23:0] h_data;
        logic        h_sop;
        logic        h_eop;
        bit          stalled;
        stalled = 1'b0;
        h_data = '0;
        h_sop = 1'b0;
        h_eop = 1'b0;
        forever begin
            @(negedge AUD_BCLK);
            if (reset) begin
                m_st = 0;
                fidx = 0;
                exp_q.delete();
                exp_ovf = 1'b0;
                stalled = 1'b0;
            end else begin
                check("fill_level", 32'(fill_level), 32'(exp_q.size()));
                check("overflow", 32'(overflow), 32'(exp_ovf));
                case (m_st)
                    0: begin
                        check("valid_idle", 32'(src_if.src_valid), 32'd0);
                        if (enable && exp_q.size() >= FRAME) m_st = 1;
                    end
                    1: begin
                        check("valid_load", 32'(src_if.src_valid), 32'd0);
                        m_st = 2;
                    end
                    default: begin
                        check("valid_stream", 32'(src_if.src_valid), 32'd1);
                        if (stalled) begin
                            check("hold_data", 32'(src_if.src_data), 32'(h_data));
                            check("hold_sop", 32'(src_if.src_sop), 32'(h_sop));
                            check("hold_eop", 32'(src_if.src_eop), 32'(h_eop));
                        end
                        if (src_if.src_ready) begin
                            stalled = 1'b0;
                            if (exp_q.size() == 0) begin
                                check("scoreboard_nonempty", 32'(exp_q.size()), 32'd1);
                            end else begin
                                e = exp_q.pop_front();
                                check("data", 32'(src_if.src_data), 32'(e));
                                check("sop", 32'(src_if.src_sop), 32'(fidx == 0));
                                check("eop", 32'(src_if.src_eop), 32'(fidx == FRAME - 1));
                            end
                            if (fidx == FRAME - 1) begin
                                fidx = 0;
                                m_st = 0;
                            end else begin
                                fidx++;
                            end
                        end else begin
                            stalled = 1'b1;
                            h_data = src_if.src_data;
                            h_sop = src_if.src_sop;
                            h_eop = src_if.src_eop;
                        end
                    end
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge AUD_BCLK);
        #1;
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        tick();
        check("rst_valid", 32'(src_if.src_valid), 32'd0);
        check("rst_sop", 32'(src_if.src_sop), 32'd0);
        check("rst_eop", 32'(src_if.src_eop), 32'd0);
        check("rst_data", 32'(src_if.src_data), 32'd0);
        check("rst_fill", 32'(fill_level), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;
    endtask

    // One LRC period per sample; the sample is scored two edges after the rise.
    task automatic feed(input int n, input int base, input int period);
        bit is_full;
        for (int k = 0; k < n; k++) begin
            lrc_in = 1'b1;
            tick();
            sample_in = 24'(base + k);
            is_full = (exp_q.size() >= DEPTH);
            tick();
            if (is_full) exp_ovf = 1'b1;
            else exp_q.push_back(24'(base + k));
            for (int i = 2; i < period / 2; i++) tick();
            lrc_in = 1'b0;
            for (int i = 0; i < period / 2; i++) tick();
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (!(m_st == 0 && exp_q.size() < FRAME) && n < 20000) begin
            tick();
            n++;
        end
        check(tag, 32'(n < 20000), 32'd1);
    endtask

    task automatic wait_fidx(input string tag, input int target);
        int n;
        n = 0;
        while (!(m_st == 2 && fidx >= target) && n < 5000) begin
            tick();
            n++;
        end
        check(tag, 32'(n < 5000), 32'd1);
    endtask

    initial begin
        int n;

        // 1: single frame at the native LRC rate
        ready_mode = 0;
        do_reset();
        enable = 1'b1;
        feed(256, 0, 64);
        wait_idle("t1_drain");
        check("t1_fill_end", 32'(fill_level), 32'd0);

        // 2: same with one-in-three ready
        do_reset();
        ready_mode = 1;
        enable = 1'b1;
        feed(256, 0, 64);
        wait_idle("t2_drain");
        check("t2_fill_end", 32'(fill_level), 32'd0);

        // 3: overflow with output held off, then two full frames
        do_reset();
        ready_mode = 0;
        enable = 1'b0;
        feed(600, 0, 8);
        check("t3_fill_sat", 32'(fill_level), 32'd512);
        check("t3_overflow", 32'(overflow), 32'd1);
        check("t3_no_valid", 32'(src_if.src_valid), 32'd0);
        enable = 1'b1;
        wait_idle("t3_drain");
        check("t3_fill_end", 32'(fill_level), 32'd0);

        // 4: enable drop mid-frame
        do_reset();
        enable = 1'b0;
        feed(512, 0, 8);
        enable = 1'b1;
        wait_fidx("t4_reach100", 100);
        enable = 1'b0;
        n = 0;
        while (m_st != 0 && n < 2000) begin
            tick();
            n++;
        end
        check("t4_frame_done", 32'(n < 2000), 32'd1);
        repeat (50) tick();
        check("t4_no_restart", 32'(src_if.src_valid), 32'd0);
        check("t4_fill_hold", 32'(fill_level), 32'd256);
        enable = 1'b1;
        wait_idle("t4_drain");

        // 5: reset mid-frame, then a fresh frame
        do_reset();
        enable = 1'b0;
        feed(256, 0, 8);
        enable = 1'b1;
        wait_fidx("t5_reach50", 50);
        do_reset();
        feed(256, 1000, 8);
        wait_idle("t5_drain");

        // 6: captures colliding with transfers, pointers wrapping
        do_reset();
        ready_mode = 2;
        enable = 1'b1;
        feed(800, 2000, 8);
        wait_idle("t6_drain");
        check("t6_fill_rem", 32'(fill_level), 32'd32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end
endmodule
